// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin slot sensors, the acceptor and the vending FSM.
// The acceptor sits on the slave side; the emitter state is exported for observation.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    logic          coin5_raw;
    logic          coin10_raw;
    logic [1:0]    coin;
    logic          reject;
    logic          jam;
    logic [PW-1:0] pending;
    logic [1:0]    emit_state;

    modport master (
        output coin5_raw, coin10_raw,
        input  coin, reject, jam, pending, emit_state
    );

    modport slave (
        input  coin5_raw, coin10_raw,
        output coin, reject, jam, pending, emit_state
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin front end: sync + debounce two slot sensors, queue each clean insertion,
// and emit one single-cycle code per coin with an idle gap after every code.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input logic            clk,
    input logic            rst_n,
    coin_acceptor_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bit 0 is the 5-unit slot, bit 1 the 10-unit slot, so a rise vector is the coin code.
    logic [1:0]         sync1, sync2, deb, deb_d, deb_nx;
    logic [1:0][CW-1:0] cnt, cnt_nx;
    logic               jam_q;

    always_comb begin
        deb_nx = deb;
        cnt_nx = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) deb_nx[i] = sync2[i];
                else                                    cnt_nx[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            cnt   <= '0;
            jam_q <= 1'b0;
        end else begin
            sync1 <= {bus.coin10_raw, bus.coin5_raw};
            sync2 <= sync1;
            deb   <= deb_nx;
            deb_d <= deb;
            cnt   <= cnt_nx;
            jam_q <= &deb_nx;
        end
    end

    // Both levels high can only coincide with a rise when jammed, so at most one push per cycle.
    logic [1:0] rise;
    logic       ev, full, empty, push, pop;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] count;
    logic          reject_q;

    assign rise  = deb & ~deb_d;
    assign ev    = (|rise) & ~(&deb);
    assign full  = (count == PW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = ev & ~full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            reject_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count + PW'(push) - PW'(pop);
            reject_q <= ev & full;
        end
    end

    state_t        state, state_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [1:0]    coin_q, coin_nx;

    // The last gap cycle may pop directly, giving one code per 1+GAP_CYCLES cycles.
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        coin_nx  = 2'b00;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    coin_nx  = mem[rd_ptr];
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                gap_nx   = GW'(GAP_CYCLES - 1);
                state_nx = GAP;
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_nx = gap_cnt - GW'(1);
                end else if (!empty) begin
                    pop      = 1'b1;
                    coin_nx  = mem[rd_ptr];
                    state_nx = EMIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            coin_q  <= 2'b00;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
            coin_q  <= coin_nx;
        end
    end

    assign bus.coin       = coin_q;
    assign bus.reject     = reject_q;
    assign bus.jam        = jam_q;
    assign bus.pending    = count;
    assign bus.emit_state = state;
endmodule
